// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter: round-robin write arbiter in front of one shared loadable register.
// A winner is chosen in IDLE, its data is latched, ld is driven for one LOAD cycle,
// and the winner is acknowledged in DONE. All outputs come straight from flops.
module reg_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] wdata,
  output logic              ld_o,
  output logic [W-1:0]      d_o,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [IW-1:0]     owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [W-1:0]    dreg_q, dreg_d;
  logic [IW-1:0]   win;
  logic            win_vld;
  logic [NREQ-1:0] own_onehot;

  // Rotating-priority search starting at ptr; scanning from the far end lets the
  // nearest pending requester overwrite the result last.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        win     = idx[IW-1:0];
        win_vld = 1'b1;
      end
    end
  end

  // State register; clr drops the FSM to IDLE without waiting for a clock edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Pointer, owner and latched data; cleared together with the FSM.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ptr_q   <= '0;
      owner_q <= '0;
      dreg_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      dreg_q  <= dreg_d;
    end
  end

  // Next-state logic: grant on any request in IDLE, advance the pointer past
  // the winner when leaving DONE (wrapping at NREQ-1 for non-power-of-two NREQ).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    dreg_d  = dreg_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          owner_d = win;
          dreg_d  = wdata[win*W +: W];
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_DONE;
      S_DONE: begin
        ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state only, so req/wdata never reach an output.
  always_comb begin
    own_onehot = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
    ld_o  = (state_q == S_LOAD);
    d_o   = dreg_q;
    busy  = (state_q != S_IDLE);
    gnt   = busy ? own_onehot : '0;
    ack   = (state_q == S_DONE) ? own_onehot : '0;
    owner = owner_q;
  end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Bench for reg_wr_arbiter: directed scenarios plus randomized requesters checked
// against a transaction-level reference model of the arbiter and the shared register.
module tb_reg_wr_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic clr;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic           ld;
  logic [W-1:0]   d;
  logic [N-1:0]   gnt, ack;
  logic [1:0]     owner;
  logic           busy;

  logic [2:0]     req3;
  logic [3*W-1:0] wdata3;
  logic           ld3;
  logic [W-1:0]   d3;
  logic [2:0]     gnt3, ack3;
  logic [1:0]     owner3;
  logic           busy3;

  logic [W-1:0]   reg_q;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int         m_phase;   // 0 idle, 1 writing, 2 acknowledging
  int         m_ptr;
  int         m_owner;
  logic [3:0] m_dreg;
  logic [3:0] m_q;
  int         waitc [N];

  always #5 clk = ~clk;

  reg_wr_arbiter #(.NREQ(N), .W(W)) u_dut (
    .clk(clk), .clr(clr), .req(req), .wdata(wdata),
    .ld_o(ld), .d_o(d), .gnt(gnt), .ack(ack), .owner(owner), .busy(busy)
  );

  reg_wr_arbiter #(.NREQ(3), .W(W)) u_dut3 (
    .clk(clk), .clr(clr), .req(req3), .wdata(wdata3),
    .ld_o(ld3), .d_o(d3), .gnt(gnt3), .ack(ack3), .owner(owner3), .busy(busy3)
  );

  // the shared 4-bit register fed by the main arbiter
  always @(posedge clk or posedge clr) begin
    if (clr)     reg_q <= '0;
    else if (ld) reg_q <= d;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_owner = 0; m_dreg = '0; m_q = '0;
    for (int j = 0; j < N; j++) waitc[j] = 0;
  endtask

  task automatic check_outputs();
    chk("ld", ld, m_phase == 1);
    chk("d", d, m_dreg);
    chk("gnt", gnt, (m_phase != 0) ? (32'd1 << m_owner) : 32'd0);
    chk("ack", ack, (m_phase == 2) ? (32'd1 << m_owner) : 32'd0);
    chk("busy", busy, m_phase != 0);
    chk("owner", owner, m_owner);
    chk("q", reg_q, m_q);
  endtask

  // advance the model by one clock using the inputs as currently driven
  task automatic model_step();
    int w;
    case (m_phase)
      0: begin
        if (req != '0) begin
          w = -1;
          for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (w < 0 && req[idx]) w = idx;
          end
          m_owner = w;
          m_dreg  = wdata[w*W +: W];
          m_phase = 1;
          for (int j = 0; j < N; j++) begin
            if (j == w)      waitc[j] = 0;
            else if (req[j]) begin
              waitc[j]++;
              chk("starve", waitc[j] > N - 1, 0);
            end else         waitc[j] = 0;
          end
        end
      end
      1: begin
        m_q     = m_dreg;
        m_phase = 2;
      end
      default: begin
        m_ptr   = (m_owner + 1) % N;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  // asynchronous clear between clock edges; outputs must fall before any edge
  task automatic do_clr_pulse();
    #1 clr = 1'b1;
    #1;
    chk("clr_ld", ld, 0);
    chk("clr_gnt", gnt, 0);
    chk("clr_ack", ack, 0);
    chk("clr_busy", busy, 0);
    chk("clr_d", d, 0);
    chk("clr_q", reg_q, 0);
    model_reset();
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    logic dropped;
    clr = 1'b1; req = '0; wdata = '0; req3 = '0; wdata3 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    chk("rst3_busy", busy3, 0);
    chk("rst3_ld", ld3, 0);
    clr = 1'b0;

    // single request from requester 2
    req = 4'b0100; wdata = 16'h0A00;
    tick();
    chk("t1_gnt", gnt, 4'b0100);
    chk("t1_ld", ld, 1);
    chk("t1_d", d, 4'hA);
    tick();
    chk("t1_ack", ack, 4'b0100);
    chk("t1_q", reg_q, 4'hA);
    chk("t1_owner", owner, 2);
    req = '0;
    tick();
    // pointer now at 3: requester 3 beats requester 0
    req = 4'b1001; wdata = 16'hC003;
    tick();
    chk("ptr3_owner", owner, 3);
    tick();
    req[3] = 1'b0;
    tick();
    tick();
    chk("ptr3_next", owner, 0);
    tick();
    req = '0;
    tick();

    // all four held high from a fresh reset
    do_clr_pulse();
    req = 4'hF; wdata = 16'h4321;
    for (int r = 0; r < 8; r++) begin
      tick();
      chk("rr_owner", owner, r % 4);
      chk("rr_d", d, (r % 4) + 1);
      tick();
      chk("rr_ack", ack, 32'd1 << (r % 4));
      tick();
      chk("rr_idle", busy, 0);
    end
    req = '0;

    // starvation: 0 re-requests right after each ack, 3 held high
    req = 4'b1001;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("alt_owner", owner, (t % 2 == 0) ? 0 : 3);
      tick();
      if (owner == 2'd0) req[0] = 1'b0;
      tick();
      req[0] = 1'b1;
    end
    req = '0;
    tick();

    // data latched at the grant edge
    do_clr_pulse();
    req = 4'b0010; wdata = 16'h0050;
    tick();
    wdata = 16'h00F0;
    chk("latch_d_load", d, 4'h5);
    tick();
    chk("latch_q", reg_q, 4'h5);
    req = '0;
    tick();

    // clear during LOAD, then re-arbitration from pointer 0
    req = 4'b0101; wdata = 16'h0201;
    tick();
    chk("mid_owner", owner, 2);
    do_clr_pulse();
    tick();
    chk("rearb_owner", owner, 0);
    tick();
    req[0] = 1'b0;
    tick();
    tick();
    chk("rearb_owner2", owner, 2);
    tick();
    chk("rearb_ack2", ack, 4'b0100);
    req = '0;
    tick();

    // wrap with three requesters
    do_clr_pulse();
    req3 = 3'b010; wdata3 = 12'h000;
    tick();
    chk("w3_first", owner3, 1);
    tick();
    req3 = '0;
    tick();
    req3 = 3'b101; wdata3 = 12'h906;
    tick();
    chk("w3_owner2", owner3, 2);
    chk("w3_d2", d3, 4'h9);
    chk("w3_gnt2", gnt3, 3'b100);
    tick();
    chk("w3_ack2", ack3, 3'b100);
    req3 = 3'b001;
    tick();
    tick();
    chk("w3_owner0", owner3, 0);
    chk("w3_d0", d3, 4'h6);
    tick();
    chk("w3_ack0", ack3, 3'b001);
    req3 = '0;
    tick();

    // randomized requesters
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_clr_pulse();
        check_outputs();
      end else begin
        for (int i = 0; i < N; i++) begin
          dropped = 1'b0;
          if (m_phase == 2 && m_owner == i && req[i]) begin
            req[i]  = 1'b0;
            dropped = 1'b1;
          end
          if (!dropped && !req[i] && $urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            wdata[i*W +: W] = W'($urandom);
          end
          if (m_phase == 1 && m_owner == i && $urandom_range(0, 1) == 1)
            wdata[i*W +: W] = W'($urandom);
        end
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
